// File: rtl/hc595_chain_driver_pkg.sv
// Shared types and constants for the 74HC595 chain driver and its display formatting neighbours.
// Optional output-enable support in the top level is selected with HC595_OE_EN.
package hc595_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_CLK_DIV = 2;

    // Counter width that never collapses to zero bits for a count of one.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hc595_chain_driver_tick_gen.sv
// Phase counter for serial pin drivers: tc is high on the last cycle of every DIV-cycle phase.
// Holding clear high parks the count at zero so the next phase starts a full DIV cycles long.
module hc595_tick_gen
    import hc595_pkg::*;
#(
    parameter int DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);

    localparam int W = clog2_min1(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/hc595_chain_driver.sv
// Serial driver for a daisy chain of 74HC595s: one handshake-accepted word per transfer, then a latch pulse.
// Define HC595_OE_EN to add an active-low output enable that stays blanked until the first word is latched.
module hc595_chain_driver
    import hc595_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              ready,
    output logic              shcp,
    output logic              stcp,
    output logic              ds
`ifdef HC595_OE_EN
    ,
    output logic              oe_n
`endif
);

    localparam int CNT_W = clog2_min1(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state, state_next;
    logic [DATA_W-1:0] sreg, sreg_next, sreg_shifted;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
    logic              ready_next, shcp_next, stcp_next, ds_next;
    logic              tick;

    hc595_tick_gen #(
        .DIV (CLK_DIV)
    ) u_tick (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .clear (state == IDLE),
        .tc    (tick)
    );

    assign sreg_shifted = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

    always_comb begin
        state_next   = state;
        sreg_next    = sreg;
        bit_cnt_next = bit_cnt;
        ready_next   = ready;
        shcp_next    = shcp;
        stcp_next    = stcp;
        ds_next      = ds;
        case (state)
            IDLE: begin
                if (data_valid && ready) begin
                    sreg_next    = data;
                    ds_next      = MSB_FIRST ? data[DATA_W-1] : data[0];
                    ready_next   = 1'b0;
                    bit_cnt_next = '0;
                    state_next   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    shcp_next  = 1'b1;
                    state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                // ds moves on the falling shcp edge so it has a full low phase to settle.
                if (tick) begin
                    shcp_next = 1'b0;
                    if (bit_cnt == LAST_BIT) begin
                        stcp_next  = 1'b1;
                        state_next = LATCH;
                    end else begin
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                        sreg_next    = sreg_shifted;
                        ds_next      = MSB_FIRST ? sreg_shifted[DATA_W-1] : sreg_shifted[0];
                        state_next   = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    stcp_next  = 1'b0;
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            ready   <= 1'b1;
            shcp    <= 1'b0;
            stcp    <= 1'b0;
            ds      <= 1'b0;
        end else begin
            state   <= state_next;
            sreg    <= sreg_next;
            bit_cnt <= bit_cnt_next;
            ready   <= ready_next;
            shcp    <= shcp_next;
            stcp    <= stcp_next;
            ds      <= ds_next;
        end
    end

`ifdef HC595_OE_EN
    // Outputs stay blanked until a real word has reached the storage registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            oe_n <= 1'b1;
        end else if (state == LATCH && tick) begin
            oe_n <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Directed bench for hc595_chain_driver: three configurations, each driving a behavioural 595 chain model.
// Output-enable checks are compiled in when HC595_OE_EN is defined.
module tb_hc595_chain_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] d0, d1;
    logic [7:0]  d2;
    logic        v0, v1, v2;
    logic        r0, sh0, st0, ds0;
    logic        r1, sh1, st1, ds1;
    logic        r2, sh2, st2, ds2;
`ifdef HC595_OE_EN
    logic        oe0, oe1, oe2;
`endif

    hc595_chain_driver #(.DATA_W(16), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut0 (
        .sys_clk(clk), .sys_rst(rst), .data(d0), .data_valid(v0),
        .ready(r0), .shcp(sh0), .stcp(st0), .ds(ds0)
`ifdef HC595_OE_EN
        , .oe_n(oe0)
`endif
    );

    hc595_chain_driver #(.DATA_W(16), .CLK_DIV(2), .MSB_FIRST(1'b0)) dut1 (
        .sys_clk(clk), .sys_rst(rst), .data(d1), .data_valid(v1),
        .ready(r1), .shcp(sh1), .stcp(st1), .ds(ds1)
`ifdef HC595_OE_EN
        , .oe_n(oe1)
`endif
    );

    hc595_chain_driver #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b1)) dut2 (
        .sys_clk(clk), .sys_rst(rst), .data(d2), .data_valid(v2),
        .ready(r2), .shcp(sh2), .stcp(st2), .ds(ds2)
`ifdef HC595_OE_EN
        , .oe_n(oe2)
`endif
    );

    // 595 chain models; the LSB-first chain is wired in reverse so the latched word reads naturally.
    logic [15:0] chain0 = '0, lat0 = '0;
    logic [15:0] chain1 = '0, lat1 = '0;
    logic [7:0]  chain2 = '0, lat2 = '0;
    always @(posedge sh0) chain0 <= {chain0[14:0], ds0};
    always @(posedge st0) lat0   <= chain0;
    always @(posedge sh1) chain1 <= {ds1, chain1[15:1]};
    always @(posedge st1) lat1   <= chain1;
    always @(posedge sh2) chain2 <= {chain2[6:0], ds2};
    always @(posedge st2) lat2   <= chain2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] data;
        logic [15:0] latched;
        logic        first_ds;
        int          rises;
        int          stcp_hi;
        int          ready_low;
    } vec_t;

    vec_t vecs [5];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] pins(input int i);
        case (i)
            0:       return {r0, sh0, st0, ds0};
            1:       return {r1, sh1, st1, ds1};
            default: return {r2, sh2, st2, ds2};
        endcase
    endfunction

    task automatic drive(input int i, input logic [15:0] d, input logic v);
        case (i)
            0:       begin d0 = d;      v0 = v; end
            1:       begin d1 = d;      v1 = v; end
            default: begin d2 = d[7:0]; v2 = v; end
        endcase
    endtask

    // One request cycle, then measure the busy window sample by sample on falling edges.
    task automatic apply_stimulus(input int i, input logic [15:0] d, output int rises,
                                  output int stcp_hi, output int ready_low,
                                  output logic first_ds, output int overlap);
        logic [3:0] p, prev;
        int n;
        @(negedge clk);
        drive(i, d, 1'b1);
        @(negedge clk);
        drive(i, d, 1'b0);
        rises = 0; stcp_hi = 0; ready_low = 0; overlap = 0; n = 0;
        p = pins(i);
        prev = p;
        first_ds = p[0];
        while (p[3] == 1'b0 && n < 2000) begin
            ready_low++;
            if (p[2] && !prev[2]) rises++;
            if (p[1]) stcp_hi++;
            if (p[1] && p[2]) overlap++;
            prev = p;
            @(negedge clk);
            p = pins(i);
            n++;
        end
        check_output("xfer_done", {31'd0, p[3]}, 32'd1);
    endtask

    int          rises, stcp_hi, ready_low, overlap, n, g;
    logic        first_ds, prev_st, stcp_seen;

    initial begin
        vecs[0] = '{16'hA5C3, 16'hA5C3, 1'b1, 16, 2, 66};
        vecs[1] = '{16'h0000, 16'h0000, 1'b0, 16, 2, 66};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16, 2, 66};
        vecs[3] = '{16'h8001, 16'h8001, 1'b1, 16, 2, 66};
        vecs[4] = '{16'h3C5A, 16'h3C5A, 1'b0, 16, 2, 66};

        rst = 1'b1;
        drive(0, 16'h0, 1'b0);
        drive(1, 16'h0, 1'b0);
        drive(2, 16'h0, 1'b0);
        repeat (3) @(negedge clk);
        check_output("reset_pins0", {28'd0, pins(0)}, 32'h8);
        check_output("reset_pins1", {28'd0, pins(1)}, 32'h8);
        check_output("reset_pins2", {28'd0, pins(2)}, 32'h8);
        rst = 1'b0;
        @(negedge clk);
        check_output("idle_pins0", {28'd0, pins(0)}, 32'h8);
`ifdef HC595_OE_EN
        check_output("oe_after_reset", {31'd0, oe0}, 32'd1);
`endif

        for (int k = 0; k < 5; k++) begin
            apply_stimulus(0, vecs[k].data, rises, stcp_hi, ready_low, first_ds, overlap);
            check_output("tbl_latched", {16'd0, lat0}, {16'd0, vecs[k].latched});
            check_output("tbl_first_ds", {31'd0, first_ds}, {31'd0, vecs[k].first_ds});
            check_output("tbl_rises", rises, vecs[k].rises);
            check_output("tbl_stcp_hi", stcp_hi, vecs[k].stcp_hi);
            check_output("tbl_ready_low", ready_low, vecs[k].ready_low);
            check_output("tbl_overlap", overlap, 0);
`ifdef HC595_OE_EN
            check_output("oe_after_xfer", {31'd0, oe0}, 32'd0);
`endif
        end

        // LSB-first ordering.
        apply_stimulus(1, 16'h0001, rises, stcp_hi, ready_low, first_ds, overlap);
        check_output("lsb_first_ds", {31'd0, first_ds}, 32'd1);
        check_output("lsb_latched", {16'd0, lat1}, 32'h0001);
        check_output("lsb_rises", rises, 16);
        apply_stimulus(1, 16'h8000, rises, stcp_hi, ready_low, first_ds, overlap);
        check_output("lsb_first_ds_b", {31'd0, first_ds}, 32'd0);
        check_output("lsb_latched_b", {16'd0, lat1}, 32'h8000);

        // Back-to-back with data changing under a held request.
        @(negedge clk);
        drive(0, 16'hFFFF, 1'b1);
        n = 0;
        prev_st = st0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (n == 10) d0 = 16'h1234;
            if (prev_st && !st0) break;
            prev_st = st0;
        end
        check_output("b2b_fall_seen", {31'd0, n < 1000}, 32'd1);
        check_output("b2b_ready_at_fall", {31'd0, r0}, 32'd1);
        check_output("b2b_first_latched", {16'd0, lat0}, 32'hFFFF);
        g = 0;
        while (g < 50) begin
            @(negedge clk);
            g++;
            if (g == 1) begin
                check_output("b2b_accept_first", {31'd0, r0}, 32'd0);
                v0 = 1'b0;
            end
            if (sh0) break;
        end
        check_output("b2b_gap", g, 3);
        n = 0;
        while (!r0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_output("b2b_second_done", {31'd0, r0}, 32'd1);
        check_output("b2b_second_latched", {16'd0, lat0}, 32'h1234);

        // Reset in the middle of a transfer.
        @(negedge clk);
        drive(0, 16'h00FF, 1'b1);
        @(negedge clk);
        v0 = 1'b0;
        rises = 0; n = 0; stcp_seen = 1'b0;
        prev_st = sh0;
        while (rises < 5 && n < 1000) begin
            @(negedge clk);
            n++;
            if (sh0 && !prev_st) rises++;
            if (st0) stcp_seen = 1'b1;
            prev_st = sh0;
        end
        check_output("abort_rises", rises, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("abort_pins", {28'd0, pins(0)}, 32'h8);
        check_output("abort_no_stcp", {31'd0, stcp_seen}, 32'd0);
        check_output("abort_latched", {16'd0, lat0}, 32'h1234);
`ifdef HC595_OE_EN
        check_output("oe_after_abort", {31'd0, oe0}, 32'd1);
`endif
        apply_stimulus(0, 16'h5A3C, rises, stcp_hi, ready_low, first_ds, overlap);
        check_output("recover_latched", {16'd0, lat0}, 32'h5A3C);

        // CLK_DIV=1, DATA_W=8.
        apply_stimulus(2, 16'h003C, rises, stcp_hi, ready_low, first_ds, overlap);
        check_output("div1_ready_low", ready_low, 17);
        check_output("div1_rises", rises, 8);
        check_output("div1_stcp_hi", stcp_hi, 1);
        check_output("div1_latched", {24'd0, lat2}, 32'h3C);
        check_output("div1_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hc595_chain_driver.md
Name: hc595_chain_driver

Overview:
Parametrised serial driver for a daisy-chain of 74HC595 shift registers (segment and LED banks).
- Accepts a DATA_W-bit word through a valid/ready handshake.
- Shifts the word out on ds/shcp at a programmable rate and bit order, then pulses stcp to latch it.
- Sits between display/LED formatting logic and the board pins. It is the generalised replacement for the fixed 16-bit free-running driver: it adds a rate divider, a bit-order mode and transfer-on-request.

Parameters:
DATA_W, 16, total chain bits (8 x number of chained 595s); must be at least 1.
CLK_DIV, 2, sys_clk cycles per shcp half-period and per stcp pulse width; must be at least 1.
MSB_FIRST, 1, 1 = data[DATA_W-1] shifted first; 0 = data[0] first.

Ports:
sys_clk  input  1  system clock; all logic on rising edge.
sys_rst  input  1  synchronous, active-high reset.
data  input  DATA_W  word to display.
data_valid  input  1  transfer request.
ready  output  1  registered; high only in IDLE; a transfer is accepted when data_valid && ready.
shcp  output  1  shift clock to the 595 chain.
stcp  output  1  storage/latch clock to the 595 chain.
ds  output  1  serial data to the first 595.

Behaviour:
- Single clock, sys_clk. Reset is synchronous, active-high: sys_rst sampled on the rising edge.
- Reset values: ready=1, shcp=0, stcp=0, ds=0, state=IDLE, divider=0, bit_cnt=0, shift register=0.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE, on accept:
  - Load data into the shift register.
  - Drive ds with the first bit (per MSB_FIRST).
  - Set ready=0, bit_cnt=0, divider=0, then go to SHIFT_LO.
  - data_valid without ready is ignored. There is no queue, so the source must hold its request.
- SHIFT_LO: shcp=0. After CLK_DIV cycles, set shcp=1 and go to SHIFT_HI. ds is stable for CLK_DIV cycles before the rising edge.
- SHIFT_HI: shcp=1. After CLK_DIV cycles, set shcp=0, then:
  - If bit_cnt==DATA_W-1: go to LATCH with stcp=1.
  - Else: bit_cnt+1, shift the register, ds=next bit on the same edge as shcp falls, go to SHIFT_LO.
- LATCH: stcp=1 for CLK_DIV cycles. Then stcp=0, ready=1, go to IDLE.
- Timing:
  - ready is low for exactly 2*CLK_DIV*DATA_W + CLK_DIV cycles after the accept cycle.
  - Exactly DATA_W shcp rising edges per transfer.
  - stcp never overlaps a shcp high phase.
- Back-to-back transfers: accept is possible in the first cycle ready=1; the minimum gap between stcp falling and the next shcp rise is CLK_DIV+1 cycles.
- Counters: divider width is clog2(CLK_DIV) (min 1); bit_cnt width is clog2(DATA_W) (min 1); the divider wraps to 0 at CLK_DIV-1.
- data changing mid-transfer has no effect; only the accepted snapshot is shifted.
- Reset mid-transfer: all outputs return to reset values next cycle with no stcp pulse, so the 595 outputs keep the previously latched word.
- Degenerate case DATA_W=1: one shcp pulse, then latch.

Optional Feature:
Macro HC595_OE_EN.
- Defined: adds output port oe_n (1 bit, reset 1).
  - oe_n goes 0 on the cycle stcp falls after the first completed transfer following reset, and stays 0 until reset.
  - This blanks power-up garbage on the 595 outputs.
- Undefined: no oe_n port. The board ties OE low.

Decomposition:
- Package hc595_pkg holds:
  - the FSM state enum (IDLE, SHIFT_LO, SHIFT_HI, LATCH);
  - a clog2-with-minimum-1 width helper function;
  - the default DATA_W/CLK_DIV constants shared with display formatting blocks.
- One natural sub-module: hc595_tick_gen. It is the CLK_DIV phase counter with clear input and a terminal-count output, and is reusable by other serial pin drivers.

Test Plan:
1. DATA_W=16, CLK_DIV=2, MSB_FIRST=1, send 16'hA5C3 -> 595 chain model latches 16'hA5C3; 16 shcp rises; stcp high 2 cycles; ready low 66 cycles.
2. MSB_FIRST=0, send 16'h0001 -> first ds bit 1, remaining 15 bits 0; model latches 16'h0001.
3. Hold data_valid high and change data to 16'h1234 during the transfer of 16'hFFFF -> 16'hFFFF latched first, then 16'h1234 accepted in the first ready cycle; gap from stcp fall to the next shcp rise is 3 cycles.
4. Pulse sys_rst after 5 shcp rises of 16'h00FF -> next cycle shcp=stcp=ds=0, ready=1; no stcp during the aborted transfer; the model's latched output is unchanged.
5. CLK_DIV=1, DATA_W=8, send 8'h3C -> ready low 17 cycles; model latches 8'h3C.
6. HC595_OE_EN defined -> oe_n=1 from reset until stcp falls after the first transfer, then 0; a later reset returns oe_n to 1.
